bcd_conv_arbiter: RTL and testbench

Shares one combinational binary-to-BCD (double-dabble) datapath among NUM_REQ requesters using round-robin arbitration. The block wraps the converter in a two-stage registered pipeline (operand stage, result stage) with valid/ready handshakes on both sides and full backpressure. Each result is tagged with the ID of the requester that supplied the operand. It sits between the display and report front-ends and the BCD conversion resource.

---
 rtl/bcd_conv_arbiter_if.sv | 27 ++
 rtl/bcd_conv_arbiter.sv | 129 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_arbiter_if.sv
// Requester/downstream bundle for the shared binary-to-BCD converter.
// master = requesters + result consumer, slave = the converter block.
interface bcd_conv_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int DIGIT   = 3,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ-1:0]       in_ready;
    logic [NUM_REQ*WIDTH-1:0] in_binary;
    logic                     out_valid;
    logic                     out_ready;
    logic [DIGIT*4-1:0]       out_bcd;
    logic [ID_W-1:0]          out_id;

    modport master (
        output in_valid, in_binary, out_ready,
        input  in_ready, out_valid, out_bcd, out_id
    );

    modport slave (
        input  in_valid, in_binary, out_ready,
        output in_ready, out_valid, out_bcd, out_id
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared double-dabble converter: operand stage S1, result stage S2,
// valid/ready on both sides with full backpressure; results tagged by requester.
module bcd_conv_arbiter #(
    parameter int WIDTH   = 8,
    parameter int DIGIT   = 3,
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_conv_arbiter_if.slave   bus
);
    localparam int          ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          BCD_W = DIGIT * 4;
    localparam int unsigned NREQ  = NUM_REQ;

    // Shift-add-3; bits shifted out of the top digit are multiples of 10^DIGIT.
    function automatic logic [BCD_W-1:0] bin2bcd(input logic [WIDTH-1:0] bin);
        logic [BCD_W-1:0] acc;
        acc = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            for (int unsigned j = 0; j < DIGIT; j++) begin
                if (acc[4*j +: 4] >= 4'd5) begin
                    acc[4*j +: 4] = acc[4*j +: 4] + 4'd3;
                end
            end
            acc = {acc[BCD_W-2:0], bin[WIDTH-1-b]};
        end
        return acc;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_bin_q,   s1_bin_d;
    logic [ID_W-1:0]   s1_id_q,    s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [BCD_W-1:0]  s2_bcd_q,   s2_bcd_d;
    logic [ID_W-1:0]   s2_id_q,    s2_id_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;

    logic               s2_en;
    logic               s1_en;
    logic               found;
    logic [31:0]        scan;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]   gnt_bin;
    logic [NUM_REQ-1:0] in_ready;
    logic               accept;

    assign s2_en = !s2_valid_q || bus.out_ready;
    assign s1_en = !s1_valid_q || s2_en;

    // Scan order rr_ptr, rr_ptr+1, ... wrapped modulo NUM_REQ (need not be a power of two).
    always_comb begin
        found   = 1'b0;
        scan    = '0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_bin = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 32'(rr_ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && (i == scan) && bus.in_valid[i]) begin
                    found     = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = ID_W'(i);
                    gnt_bin   = bus.in_binary[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign in_ready = (s1_en && !rst) ? gnt_oh : '0;
    assign accept   = |in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bin_d   = s1_bin_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_bcd_d   = s2_bcd_q;
        s2_id_d    = s2_id_q;
        rr_ptr_d   = rr_ptr_q;

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_bcd_d = bin2bcd(s1_bin_q);
                s2_id_d  = s1_id_q;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_bin_d   = gnt_bin;
            s1_id_d    = gnt_idx;
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (s2_en) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_bcd_q   <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bin_q   <= s1_bin_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_bcd_q   <= s2_bcd_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_bcd   = s2_bcd_q;
    assign bus.out_id    = s2_id_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_conv_arbiter;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    logic [N-1:0] acc_q;

    bcd_conv_arbiter_if #(.WIDTH(W), .DIGIT(D), .NUM_REQ(N)) bus ();
    bcd_conv_arbiter_if #(.WIDTH(W), .DIGIT(2), .NUM_REQ(2)) bus2 ();

    bcd_conv_arbiter #(.WIDTH(W), .DIGIT(D), .NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bcd_conv_arbiter #(.WIDTH(W), .DIGIT(2), .NUM_REQ(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: results in flight, oldest first; vis = presented on the output.
    typedef struct packed {
        logic [7:0] v;
        logic [1:0] id;
        logic       vis;
    } item_t;

    item_t q[$];
    int    rr = 0;

    // Two results may be in flight; a slot frees when the head leaves this cycle.
    function automatic int m_grant();
        if (rst || !(q.size() < 2 || bus.out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (bus.in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [11:0] exp_bcd(input int v, input int nd);
        int r;
        logic [11:0] res;
        r   = v % (10 ** nd);
        res = '0;
        for (int j = 0; j < nd; j++) begin
            res[4*j +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    always @(posedge clk) begin : model
        int    g;
        item_t it;
        g = m_grant();
        if (rst) begin
            q.delete();
            rr = 0;
        end else begin
            if (q.size() > 0 && q[0].vis && bus.out_ready) void'(q.pop_front());
            if (q.size() > 0) begin
                it     = q[0];
                it.vis = 1'b1;
                q[0]   = it;
            end
            if (g >= 0) begin
                it.v   = bus.in_binary[g*W +: W];
                it.id  = 2'(g);
                it.vis = 1'b0;
                q.push_back(it);
                rr = (g + 1) % N;
            end
        end
    end

    always @(posedge clk) acc_q <= bus.in_valid & bus.in_ready;

    always @(negedge clk) begin : compare
        int   g;
        logic ev;
        if (chk_en) begin
            g  = m_grant();
            chk("in_ready", 32'(bus.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            ev = (q.size() > 0) && q[0].vis;
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) begin
                chk("out_bcd", 32'(bus.out_bcd), 32'(exp_bcd(int'(q[0].v), D)));
                chk("out_id", 32'(bus.out_id), 32'(q[0].id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0]  sv[6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200};
    logic [11:0] se[6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h200};
    logic [7:0]  corner[7] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd255};

    initial begin : main
        int         ids[$];
        int         exp_ids[6];
        logic [3:0] exp_alt[4];
        logic [11:0] snap_bcd;
        logic [1:0]  snap_id;
        int         n_out;
        int         n_one;

        exp_ids = '{0, 1, 2, 3, 0, 1};
        exp_alt = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        bus2.in_valid  = 2'b01;
        bus2.in_binary = {8'd0, 8'd255};
        bus2.out_ready = 1'b1;

        rst           = 1'b1;
        bus.in_valid  = '1;
        bus.in_binary = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_bcd", 32'(bus.out_bcd), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        bus.in_valid = '0;
        rst          = 1'b0;

        // single request from requester 2
        bus.in_binary[2*W +: W] = 8'd255;
        bus.in_valid[2]         = 1'b1;
        step();
        bus.in_valid[2] = 1'b0;
        step();
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_bcd", 32'(bus.out_bcd), 32'h255);
        chk("single_id", 32'(bus.out_id), 2);
        step();
        chk("single_valid_fall", 32'(bus.out_valid), 0);

        // back-to-back value sweep on requester 0
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                bus.in_binary[0 +: W] = sv[i];
                bus.in_valid[0]       = 1'b1;
            end else begin
                bus.in_valid[0] = 1'b0;
            end
            step();
            if (i > 0) begin
                chk("sweep_valid", 32'(bus.out_valid), 1);
                chk("sweep_bcd", 32'(bus.out_bcd), 32'(se[i-1]));
                chk("sweep_id", 32'(bus.out_id), 0);
            end
        end

        // round-robin with all requesters continuously valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) bus.in_binary[i*W +: W] = 8'(17 + 41 * i);
        bus.in_valid = '1;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("rr_onehot", 32'($onehot(bus.in_ready)), 1);
            step();
            if (bus.out_valid) ids.push_back(int'(bus.out_id));
        end
        chk("rr_count", ids.size(), 8);
        if (ids.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk("rr_seq", ids[k], exp_ids[k]);
        end
        bus.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_alt", 32'(bus.in_ready), 32'(exp_alt[k]));
            step();
        end

        // backpressure under full load
        bus.in_valid = '1;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        #1;
        snap_bcd = bus.out_bcd;
        snap_id  = bus.out_id;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_bcd", 32'(bus.out_bcd), 32'(snap_bcd));
            chk("stall_id", 32'(bus.out_id), 32'(snap_id));
            chk("stall_in_ready", 32'(bus.in_ready), 0);
        end
        step();
        chk("stall_bcd_end", 32'(bus.out_bcd), 32'(snap_bcd));
        bus.out_ready = 1'b1;
        #1;
        chk("release_accept", 32'($onehot(bus.in_ready)), 1);
        step();
        step();

        // reset with two operands in flight
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        step();
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_out_bcd", 32'(bus.out_bcd), 0);
        chk("midrst_out_id", 32'(bus.out_id), 0);
        rst           = 1'b0;
        bus.in_valid  = 4'b1010;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_first_grant", 32'(bus.in_ready), 32'b0010);

        // withdrawal of requester 1 while S1 is full and stalled
        bus.in_valid = '0;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0101;
        step();
        step();
        bus.in_binary[1*W +: W] = 8'd77;
        bus.in_valid[1]         = 1'b1;
        step();
        chk("withdraw_blocked", 32'(bus.in_ready), 0);
        step();
        bus.in_valid[1] = 1'b0;
        bus.out_ready   = 1'b1;
        n_out = 0;
        n_one = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.out_valid) begin
                n_out++;
                if (bus.out_id == 2'd1) n_one++;
            end
        end
        chk("withdraw_no_id1", n_one, 0);
        chk("withdraw_others", n_out, 10);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (acc_q[i] || !bus.in_valid[i]) begin
                    bus.in_valid[i] = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 4) == 0)
                        bus.in_binary[i*W +: W] = corner[$urandom_range(0, 6)];
                    else
                        bus.in_binary[i*W +: W] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.in_valid[i] = 1'b0;
                end
            end
            step();
        end
        rst           = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        chk("d2_valid", 32'(bus2.out_valid), 1);
        chk("d2_bcd", 32'(bus2.out_bcd), 32'h55);
        chk("d2_id", 32'(bus2.out_id), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
